// File: rtl/cfg_regfile_pkg.sv
// Shared address map and CMD_STATUS bit positions for the cfg register bank.
package cfg_regfile_pkg;

    localparam int unsigned ADDR_ID         = 0;
    localparam int unsigned ADDR_SCRATCH    = 1;
    localparam int unsigned ADDR_PULSE      = 2;
    localparam int unsigned ADDR_CMD_STATUS = 3;
    localparam int unsigned ADDR_CMD_PUSH   = 4;
    localparam int unsigned ADDR_CTRL_BASE  = 5;
    localparam int unsigned ADDR_STAT_BASE  = 16;

    localparam int unsigned FULL_BIT  = 16;
    localparam int unsigned EMPTY_BIT = 17;
    localparam int unsigned OVF_BIT   = 31;

endpackage

// File: rtl/cfg_fifo.sv
// First-word-fall-through command FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module cfg_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign level   = level_q;
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cfg_regfile.sv
// Configuration register bank: ID, scratch, pulse, control/status words and a
// command FIFO fed by register writes and drained over a valid/ready stream.
module cfg_regfile
    import cfg_regfile_pkg::*;
#(
    parameter int unsigned AXI_WIDTH  = 32,
    parameter int unsigned CFG_AWIDTH = 5,
    parameter int unsigned CTRL_NB    = 4,
    parameter int unsigned STAT_NB    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [AXI_WIDTH-1:0] ID_VALUE = AXI_WIDTH'(32'h5AC0_0100)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXI_WIDTH-1:0]         cfg_wr_data,
    input  logic [CFG_AWIDTH-1:0]        cfg_wr_addr,
    input  logic                         cfg_wr_en,
    input  logic [CFG_AWIDTH-1:0]        cfg_rd_addr,
    input  logic                         cfg_rd_en,
    output logic [AXI_WIDTH-1:0]         cfg_rd_data,
    output logic [CTRL_NB*AXI_WIDTH-1:0] ctrl_regs,
    output logic [AXI_WIDTH-1:0]         ctrl_pulse,
    input  logic [STAT_NB*AXI_WIDTH-1:0] stat_regs,
    output logic [AXI_WIDTH-1:0]         cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [CTRL_NB-1:0][AXI_WIDTH-1:0] ctrl_q;
    logic [AXI_WIDTH-1:0]              scratch_q;
    logic [AXI_WIDTH-1:0]              pulse_q;
    logic [AXI_WIDTH-1:0]              rd_data_q;
    logic                              ovf_q;

    int unsigned          wr_idx;
    int unsigned          rd_idx;
    logic                 push_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic [31:0]          level_ext;
    logic [AXI_WIDTH-1:0] status_word;
    logic [AXI_WIDTH-1:0] rd_mux;

    assign wr_idx   = 32'(cfg_wr_addr);
    assign rd_idx   = 32'(cfg_rd_addr);
    assign push_req = cfg_wr_en && (wr_idx == ADDR_CMD_PUSH);

    cfg_fifo #(
        .WIDTH (AXI_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (cfg_wr_data),
        .pop       (cmd_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (cmd_data)
    );

    assign cmd_valid   = ~fifo_empty;
    assign ctrl_regs   = ctrl_q;
    assign ctrl_pulse  = pulse_q;
    assign cfg_rd_data = rd_data_q;
    assign level_ext   = 32'(fifo_level);

    always_comb begin
        status_word            = '0;
        status_word[15:0]      = level_ext[15:0];
        status_word[FULL_BIT]  = fifo_full;
        status_word[EMPTY_BIT] = fifo_empty;
        status_word[OVF_BIT]   = ovf_q;
    end

    always_comb begin
        rd_mux = '0;
        if (rd_idx == ADDR_ID) begin
            rd_mux = ID_VALUE;
        end else if (rd_idx == ADDR_SCRATCH) begin
            rd_mux = scratch_q;
        end else if (rd_idx == ADDR_CMD_STATUS) begin
            rd_mux = status_word;
        end
        for (int unsigned k = 0; k < CTRL_NB; k++) begin
            if (rd_idx == ADDR_CTRL_BASE + k) rd_mux = ctrl_q[k];
        end
        for (int unsigned k = 0; k < STAT_NB; k++) begin
            if (rd_idx == ADDR_STAT_BASE + k) rd_mux = stat_regs[k*AXI_WIDTH +: AXI_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            pulse_q   <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pulse_q <= '0;
            if (cfg_wr_en && wr_idx == ADDR_PULSE)   pulse_q   <= cfg_wr_data;
            if (cfg_wr_en && wr_idx == ADDR_SCRATCH) scratch_q <= cfg_wr_data;
            for (int unsigned k = 0; k < CTRL_NB; k++) begin
                if (cfg_wr_en && wr_idx == ADDR_CTRL_BASE + k) ctrl_q[k] <= cfg_wr_data;
            end
            // Full implies non-empty, so a drop happens exactly when the consumer stalls.
            if (push_req && fifo_full && !cmd_ready) begin
                ovf_q <= 1'b1;
            end else if (cfg_wr_en && wr_idx == ADDR_CMD_STATUS && cfg_wr_data[OVF_BIT]) begin
                ovf_q <= 1'b0;
            end
            if (cfg_rd_en) rd_data_q <= rd_mux;
        end
    end

endmodule

// File: tb/tb_cfg_regfile.sv
// Directed bench for cfg_regfile with scoreboard queues for reads and commands.
module tb_cfg_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cfg_wr_data;
    logic [4:0]   cfg_wr_addr;
    logic         cfg_wr_en;
    logic [4:0]   cfg_rd_addr;
    logic         cfg_rd_en;
    logic [31:0]  cfg_rd_data;
    logic [127:0] ctrl_regs;
    logic [31:0]  ctrl_pulse;
    logic [127:0] stat_regs;
    logic [31:0]  cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_exp [$];
    string       rd_tag [$];
    logic [31:0] cmd_exp [$];

    cfg_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr_data (cfg_wr_data),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_en   (cfg_rd_en),
        .cfg_rd_data (cfg_rd_data),
        .ctrl_regs   (ctrl_regs),
        .ctrl_pulse  (ctrl_pulse),
        .stat_regs   (stat_regs),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_wr_addr = a;
        cfg_wr_data = d;
        cfg_wr_en   = 1'b1;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    // Start a read; the expected word waits in the scoreboard until data returns.
    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string t);
        cfg_rd_addr = a;
        cfg_rd_en   = 1'b1;
        rd_exp.push_back(e);
        rd_tag.push_back(t);
        tick();
        cfg_rd_en = 1'b0;
        check(rd_tag.pop_front(), cfg_rd_data, rd_exp.pop_front());
    endtask

    task automatic push_word(input logic [31:0] d);
        if (cmd_exp.size() < 8) cmd_exp.push_back(d);
        wr(5'd4, d);
    endtask

    task automatic drain(input string tag);
        cmd_ready = 1'b1;
        for (int c = 0; c < 30 && cmd_exp.size() > 0; c++) begin
            if (cmd_valid) check(tag, cmd_data, cmd_exp.pop_front());
            tick();
        end
        cmd_ready = 1'b0;
        check({tag, "_left"}, cmd_exp.size(), 0);
        check({tag, "_valid"}, cmd_valid, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_wr_data = '0;
        cfg_wr_addr = '0;
        cfg_wr_en   = 1'b0;
        cfg_rd_addr = '0;
        cfg_rd_en   = 1'b0;
        stat_regs   = '0;
        cmd_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", cmd_valid, 1'b0);
        check("rst_ctrl", ctrl_regs, '0);
        check("rst_pulse", ctrl_pulse, '0);
        check("rst_rdata", cfg_rd_data, '0);
        rd(5'd0, 32'h5AC0_0100, "id");
        rd(5'd1, 32'h0, "scratch_rst");
        rd(5'd3, 32'h0002_0000, "status_rst");

        wr(5'd5, 32'hDEAD_BEEF);
        check("ctrl0_wr", ctrl_regs[31:0], 32'hDEAD_BEEF);
        wr(5'd1, 32'h0000_1234);
        rd(5'd1, 32'h0000_1234, "scratch_rb");
        rd(5'd5, 32'hDEAD_BEEF, "ctrl0_rb");
        stat_regs[31:0]   = 32'h0000_CAFE;
        stat_regs[127:96] = 32'h1357_9BDF;
        rd(5'd16, 32'h0000_CAFE, "stat0");
        rd(5'd19, 32'h1357_9BDF, "stat3");
        rd(5'd9, 32'h0, "unmapped9");
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 32'h5AC0_0100, "id_ro");

        // Same-cycle read and write of scratch returns the old value.
        cfg_wr_addr = 5'd1;
        cfg_wr_data = 32'h5555_AAAA;
        cfg_wr_en   = 1'b1;
        rd(5'd1, 32'h0000_1234, "rd_wr_same");
        cfg_wr_en = 1'b0;
        rd(5'd1, 32'h5555_AAAA, "scratch_new");

        wr(5'd2, 32'h0000_0005);
        check("pulse_hi", ctrl_pulse, 32'h5);
        tick();
        check("pulse_lo", ctrl_pulse, 32'h0);
        rd(5'd2, 32'h0, "pulse_rd");

        for (int i = 1; i <= 9; i++) push_word(32'(i));
        rd(5'd3, 32'h8001_0008, "status_ovf");
        check("head_first", cmd_data, 32'h1);
        drain("drain1");
        rd(5'd3, 32'h8002_0000, "status_empty_ovf");
        wr(5'd3, 32'h8000_0000);
        rd(5'd3, 32'h0002_0000, "status_clr");

        for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
        check("simul_head", cmd_data, cmd_exp.pop_front());
        cmd_ready = 1'b1;
        cmd_exp.push_back(32'hAA);
        wr(5'd4, 32'hAA);
        cmd_ready = 1'b0;
        rd(5'd3, 32'h0001_0008, "status_simul");
        drain("drain2");
        rd(5'd3, 32'h0002_0000, "status_after2");

        for (int i = 0; i < 3; i++) push_word(32'h70 + 32'(i));
        wr(5'd5, 32'h0000_00FF);
        rd(5'd5, 32'h0000_00FF, "ctrl0_ff");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd_exp.delete();
        check("mid_rst_valid", cmd_valid, 1'b0);
        check("mid_rst_ctrl", ctrl_regs, '0);
        check("mid_rst_rdata", cfg_rd_data, '0);
        rd(5'd3, 32'h0002_0000, "mid_rst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
